keypoint_writer: RTL and testbench

- Upstream stage of the keypoint UART sender.
- Accepts detected keypoints from the extrema detector, one octave at a time (octave 0, then 1, then 2).
- Packs each keypoint into a BIT_DEPTH-bit word and writes it to the keypoint BRAM, inserting a zero separator word after each octave.
- Zero-fills the rest of the BRAM, then pulses done_out; that pulse drives the sender's img_ready input.

---
 rtl/keypoint_writer.sv | 139 +++++++++++++
 tb/tb_keypoint_writer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypoint_writer.sv
// Packs detected keypoints, one octave at a time, into keypoint BRAM words.
// A zero separator follows each octave, and the rest of the BRAM is zero-filled before done_out.
module keypoint_writer #(
  parameter int BRAM_LENGTH = 1000,
  parameter int BIT_DEPTH   = 13
) (
  input  logic                           clk,
  input  logic                           rst_in_n,
  input  logic                           start_in,
  input  logic                           kp_valid_in,
  output logic                           kp_ready_out,
  input  logic [5:0]                     kp_x_in,
  input  logic [5:0]                     kp_y_in,
  input  logic                           octave_end_in,
  output logic                           wr_en_out,
  output logic [$clog2(BRAM_LENGTH)-1:0] wr_addr_out,
  output logic [BIT_DEPTH-1:0]           wr_data_out,
  output logic                           busy_out,
  output logic                           done_out,
  output logic [15:0]                    dropped_out
);

  localparam int AW = $clog2(BRAM_LENGTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   LEN  = (CW+1)'(BRAM_LENGTH);
  localparam logic [CW-1:0] LAST = CW'(BRAM_LENGTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_SEP,
    S_FILL,
    S_DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   addr;
  logic [1:0]      octave;
  logic [BIT_DEPTH-1:0] pack_w;
  logic [CW:0]     need;
  logic            fits;
  logic            accept;

  assign accept = kp_valid_in & kp_ready_out;

  always_comb begin
    pack_w = '0;
    case (octave)
      2'd0:    pack_w = BIT_DEPTH'({kp_x_in, kp_y_in, 1'b1});
      2'd1:    pack_w = BIT_DEPTH'({kp_x_in[4:0], kp_y_in[4:0], 1'b1});
      default: pack_w = BIT_DEPTH'({kp_x_in[3:0], kp_y_in[3:0], 1'b1});
    endcase
  end

  // Keep room for every separator still owed this frame (3 - octave of them).
  always_comb begin
    need = {1'b0, addr} + (CW+1)'(2'd3 - octave);
    fits = (need < LEN);
  end

  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state        <= S_IDLE;
      addr         <= '0;
      octave       <= '0;
      wr_en_out    <= 1'b0;
      wr_addr_out  <= '0;
      wr_data_out  <= '0;
      kp_ready_out <= 1'b0;
      busy_out     <= 1'b0;
      done_out     <= 1'b0;
      dropped_out  <= '0;
    end else begin
      wr_en_out <= 1'b0;
      case (state)
        S_IDLE: begin
          done_out <= 1'b0;
          if (start_in) begin
            state        <= S_COLLECT;
            addr         <= '0;
            octave       <= '0;
            dropped_out  <= '0;
            busy_out     <= 1'b1;
            kp_ready_out <= 1'b1;
          end
        end
        S_COLLECT: begin
          if (accept) begin
            if (fits) begin
              wr_en_out   <= 1'b1;
              wr_addr_out <= addr[AW-1:0];
              wr_data_out <= pack_w;
              addr        <= addr + CW'(1);
            end else if (dropped_out != 16'hFFFF) begin
              dropped_out <= dropped_out + 16'd1;
            end
          end
          if (octave_end_in) begin
            state        <= S_SEP;
            kp_ready_out <= 1'b0;
          end
        end
        S_SEP: begin
          wr_en_out   <= 1'b1;
          wr_addr_out <= addr[AW-1:0];
          wr_data_out <= '0;
          addr        <= addr + CW'(1);
          if (octave != 2'd2) begin
            octave       <= octave + 2'd1;
            state        <= S_COLLECT;
            kp_ready_out <= 1'b1;
          end else if (addr == LAST) begin
            state    <= S_DONE;
            done_out <= 1'b1;
          end else begin
            state <= S_FILL;
          end
        end
        S_FILL: begin
          wr_en_out   <= 1'b1;
          wr_addr_out <= addr[AW-1:0];
          wr_data_out <= '0;
          addr        <= addr + CW'(1);
          if (addr == LAST) begin
            state    <= S_DONE;
            done_out <= 1'b1;
          end
        end
        S_DONE: begin
          done_out <= 1'b0;
          busy_out <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypoint_writer.sv
// Scoreboard bench for keypoint_writer with a 16-word BRAM.
module tb_keypoint_writer;
  localparam int L  = 16;
  localparam int AW = 4;
  localparam int BD = 13;

  logic          clk;
  logic          rst_in_n;
  logic          start_in;
  logic          kp_valid_in;
  logic          kp_ready_out;
  logic [5:0]    kp_x_in;
  logic [5:0]    kp_y_in;
  logic          octave_end_in;
  logic          wr_en_out;
  logic [AW-1:0] wr_addr_out;
  logic [BD-1:0] wr_data_out;
  logic          busy_out;
  logic          done_out;
  logic [15:0]   dropped_out;

  keypoint_writer #(.BRAM_LENGTH(L), .BIT_DEPTH(BD)) dut (
    .clk           (clk),
    .rst_in_n      (rst_in_n),
    .start_in      (start_in),
    .kp_valid_in   (kp_valid_in),
    .kp_ready_out  (kp_ready_out),
    .kp_x_in       (kp_x_in),
    .kp_y_in       (kp_y_in),
    .octave_end_in (octave_end_in),
    .wr_en_out     (wr_en_out),
    .wr_addr_out   (wr_addr_out),
    .wr_data_out   (wr_data_out),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .dropped_out   (dropped_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [BD-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_cmp    = 0;
  int  n_bad    = 0;
  int  cyc      = 0;
  int  done_cnt = 0;
  int  done_cyc = 0;
  int  c0       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every write must match the head of the expected-write queue.
  always @(negedge clk) begin
    if (rst_in_n && wr_en_out) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr %0d data %0h with nothing expected", wr_addr_out, wr_data_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr_out), 32'(mon_e.a));
        check("wr_data", 32'(wr_data_out), 32'(mon_e.d));
      end
    end
    if (rst_in_n && done_out) begin
      done_cnt++;
      done_cyc = cyc;
      check("busy_at_done", 32'(busy_out), 32'd1);
    end
  end

  task automatic push(input int a, input logic [BD-1:0] d);
    wr_t e;
    e.a = AW'(a);
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic push_zeros(input int from, input int to);
    for (int i = from; i <= to; i++) push(i, '0);
  endtask

  task automatic start_frame();
    @(negedge clk);
    done_cnt = 0;
    start_in = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    start_in = 1'b0;
  endtask

  task automatic beat(input logic [5:0] x, input logic [5:0] y, input logic endf, input logic vld);
    int n;
    n = 0;
    @(negedge clk);
    while (!kp_ready_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!kp_ready_out) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: kp_ready_out stayed %0b, expected 1", kp_ready_out);
    end
    kp_valid_in   = vld;
    kp_x_in       = x;
    kp_y_in       = y;
    octave_end_in = endf;
    @(posedge clk);
    #1;
    kp_valid_in   = 1'b0;
    octave_end_in = 1'b0;
  endtask

  task automatic finish_frame(input string name, input int lo, input int hi, input int drops);
    int n;
    int d;
    n = 0;
    while (done_cnt == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (done_cnt == 0) begin
      n_bad++;
      $display("FAIL %s_done_timeout: done_out never seen within %0d cycles", name, n);
    end else begin
      d = done_cyc - c0;
      if (d < lo || d > hi) begin
        n_bad++;
        $display("FAIL %s_done_latency: got %0d cycles, expected %0d..%0d", name, d, lo, hi);
      end
    end
    repeat (3) @(negedge clk);
    check({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_busy_after"}, 32'(busy_out), 32'd0);
    check({name, "_dropped"}, 32'(dropped_out), 32'(drops));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_in_n      = 1'b1;
    start_in      = 1'b0;
    kp_valid_in   = 1'b0;
    kp_x_in       = '0;
    kp_y_in       = '0;
    octave_end_in = 1'b0;
    #2 rst_in_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {wr_en_out, wr_addr_out, wr_data_out, kp_ready_out, busy_out, done_out}, '0);
    check("rst_dropped", 32'(dropped_out), 32'd0);
    rst_in_n = 1'b1;

    // Frame 1: one octave-0 keypoint, two empty octaves, 12 fill words.
    push(0, 13'h0293);
    push_zeros(1, 15);
    start_frame();
    beat(6'd5, 6'd9, 1'b1, 1'b1);
    beat('0, '0, 1'b1, 1'b0);
    beat('0, '0, 1'b1, 1'b0);
    finish_frame("f1", 17, 19, 0);

    // Frame 2: octave 1/2 packing, a keypoint coinciding with octave_end, and a start while busy.
    push(0, 13'h0000);
    push(1, 13'h0001);
    push(2, 13'h07FF);
    push(3, 13'h0000);
    push(4, 13'h01FF);
    push_zeros(5, 15);
    start_frame();
    beat('0, '0, 1'b1, 1'b0);
    @(negedge clk);
    start_in = 1'b1;
    @(posedge clk);
    #1 start_in = 1'b0;
    beat(6'd0, 6'd0, 1'b0, 1'b1);
    beat(6'h3F, 6'h3F, 1'b1, 1'b1);
    beat(6'h3F, 6'h1F, 1'b1, 1'b1);
    finish_frame("f2", 1, 200, 0);

    // Frame 3: 20 keypoints in octave 0, only 13 fit ahead of the 3 separators.
    for (int i = 0; i < 13; i++) push(i, {6'(i), 6'(19 - i), 1'b1});
    push_zeros(13, 15);
    start_frame();
    for (int i = 0; i < 20; i++) beat(6'(i), 6'(19 - i), 1'b0, 1'b1);
    beat('0, '0, 1'b1, 1'b0);
    beat('0, '0, 1'b1, 1'b0);
    beat('0, '0, 1'b1, 1'b0);
    finish_frame("f3", 1, 200, 7);

    // Frame 4: asynchronous reset in the middle of COLLECT.
    push(0, {6'd1, 6'd2, 1'b1});
    push(1, {6'd3, 6'd4, 1'b1});
    start_frame();
    done_cnt = 0;
    beat(6'd1, 6'd2, 1'b0, 1'b1);
    beat(6'd3, 6'd4, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    #2 rst_in_n = 1'b0;
    #1;
    check("midrst_outputs", {wr_en_out, wr_addr_out, wr_data_out, kp_ready_out, busy_out, done_out}, '0);
    check("midrst_dropped", 32'(dropped_out), 32'd0);
    check("midrst_writes_left", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    rst_in_n = 1'b1;

    // Frame 5: clean frame after reset, starting at address 0.
    push_zeros(0, 15);
    start_frame();
    beat('0, '0, 1'b1, 1'b0);
    beat('0, '0, 1'b1, 1'b0);
    beat('0, '0, 1'b1, 1'b0);
    finish_frame("f5", 1, 200, 0);

    // Valid keypoints offered in IDLE are never accepted.
    @(negedge clk);
    kp_valid_in = 1'b1;
    kp_x_in     = 6'd7;
    kp_y_in     = 6'd7;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_ready", 32'(kp_ready_out), 32'd0);
    end
    kp_valid_in = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
